// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub.
// The master side issues operations and the slave side returns results and status.
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_start;
  logic             in_mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_borrow;
  logic [WIDTH-1:0] out_sub;
  logic             out_borrow;
  logic             out_overflow;
  logic             out_zero;
  logic             out_busy;
  logic             out_done;

  modport master (
    output in_start, in_mode, in_a, in_b, in_borrow,
    input  out_sub, out_borrow, out_overflow, out_zero, out_busy, out_done
  );

  modport slave (
    input  in_start, in_mode, in_a, in_b, in_borrow,
    output out_sub, out_borrow, out_overflow, out_zero, out_busy, out_done
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// Subtraction is carried out as a + ~b + ~borrow_in, so one adder serves both modes.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4    // WIDTH must be an integer multiple of CHUNK
) (
  input logic              in_clk,
  input logic              in_rst_n,
  serial_addsub_if.slave   bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mode_q, mode_d;
  logic               cy_q, cy_d;
  logic [WIDTH-1:0]   sub_q, sub_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [CHUNK-1:0]   a_slice;
  logic [CHUNK-1:0]   b_slice;
  logic [CHUNK:0]     chunk_sum;
  logic               last_chunk;
  logic               start_accept;

  assign last_chunk   = (idx_q == IDX_W'(N - 1));
  assign start_accept = (state_q != RUN) && bus.in_start;

  // State register; reset has priority, so a start sampled during reset is dropped.
  always_ff @(posedge in_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!in_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sub_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sub_q    <= sub_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // NOTE: latched operands and running carry need no reset; they are always loaded before use.
  always_ff @(posedge in_clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    mode_q <= mode_d;
    cy_q   <= cy_d;
  end

  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.in_start ? RUN : IDLE;
      RUN:     state_d = last_chunk ? DONE : RUN;
      DONE:    state_d = bus.in_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In subtract mode the subtrahend is inverted chunk by chunk.
  always_comb begin
    a_slice   = a_q[idx_q*CHUNK +: CHUNK];
    b_slice   = b_q[idx_q*CHUNK +: CHUNK] ^ {CHUNK{~mode_q}};
    chunk_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, cy_q};
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    cy_d     = cy_q;
    idx_d    = idx_q;
    sub_d    = sub_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (start_accept) begin
      a_d    = bus.in_a;
      b_d    = bus.in_b;
      mode_d = bus.in_mode;
      cy_d   = bus.in_mode ? bus.in_borrow : ~bus.in_borrow;
      idx_d  = '0;
    end else if (state_q == RUN) begin
      sub_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      cy_d  = chunk_sum[CHUNK];
      idx_d = last_chunk ? '0 : idx_q + IDX_W'(1);
      if (last_chunk) begin
        // A carry out of a + ~b + ~bin means no borrow was needed.
        borrow_d = mode_q ? chunk_sum[CHUNK] : ~chunk_sum[CHUNK];
        ovf_d    = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ ~mode_q)) &&
                   (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
        zero_d   = (sub_d == '0);
      end
    end
  end

  always_comb begin
    bus.out_busy     = (state_q == RUN);
    bus.out_done     = (state_q == DONE);
    bus.out_sub      = sub_q;
    bus.out_borrow   = borrow_q;
    bus.out_overflow = ovf_q;
    bus.out_zero     = zero_q;
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=16, CHUNK=4): vector table,
// random operations against a reference model, and hand-written corner sequences.
module tb_serial_addsub;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  typedef struct {
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] sub;
    logic        bor;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t sb_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic mode, input logic [15:0] a,
                                 input logic [15:0] b, input logic bin);
    vec_t        v;
    logic [16:0] full;
    v.mode = mode; v.a = a; v.b = b; v.bin = bin;
    if (mode) full = {1'b0, a} + {1'b0, b} + {16'd0, bin};
    else      full = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    v.sub  = full[15:0];
    v.bor  = full[16];
    v.ovf  = mode ? (a[15] == b[15]) && (v.sub[15] != a[15])
                  : (a[15] != b[15]) && (v.sub[15] != a[15]);
    v.zero = (v.sub == 16'd0);
    return v;
  endfunction

  function automatic vec_t mk(input logic mode, input logic [15:0] a, input logic [15:0] b,
                              input logic bin, input logic [15:0] sub, input logic bor,
                              input logic ovf, input logic zero);
    vec_t v;
    v.mode = mode; v.a = a; v.b = b; v.bin = bin;
    v.sub = sub; v.bor = bor; v.ovf = ovf; v.zero = zero;
    return v;
  endfunction

  // Called at a negedge; drives a one-cycle start and returns at the next negedge.
  task automatic drive_start(input vec_t v, input bit push);
    bus.in_mode   = v.mode;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_borrow = v.bin;
    bus.in_start  = 1'b1;
    if (push) sb_q.push_back(v);
    @(negedge clk);
    bus.in_start = 1'b0;
    check("busy_after_start", 32'(bus.out_busy), 32'd1);
  endtask

  // Waits for out_done with a bounded cycle budget, then pops and compares the scoreboard.
  task automatic wait_done(input string tag, input int exp_lat);
    int   n = 0;
    vec_t e;
    while (!bus.out_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    if (!bus.out_done) return;
    check({tag, "_busy_in_done"}, 32'(bus.out_busy), 32'd0);
    check({tag, "_sub"},  32'(bus.out_sub), 32'(e.sub));
    check({tag, "_bor"},  32'(bus.out_borrow), 32'(e.bor));
    check({tag, "_ovf"},  32'(bus.out_overflow), 32'(e.ovf));
    check({tag, "_zero"}, 32'(bus.out_zero), 32'(e.zero));
  endtask

  task automatic run_op(input string tag, input vec_t v);
    drive_start(v, 1'b1);
    wait_done(tag, N);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.out_done), 32'd0);
    check({tag, "_sub_hold"}, 32'(bus.out_sub), 32'(v.sub));
  endtask

  initial begin
    vec_t va, vb, vc;
    int   pulses;

    vecs[0] = mk(1'b0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vecs[2] = mk(1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    vecs[3] = mk(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    vecs[4] = mk(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    vecs[5] = mk(1'b0, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    vecs[6] = mk(1'b0, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vecs[7] = mk(1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    bus.in_start = 1'b0; bus.in_mode = 1'b0; bus.in_borrow = 1'b0;
    bus.in_a = '0; bus.in_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.out_busy), 32'd0);
    check("rst_done",   32'(bus.out_done), 32'd0);
    check("rst_sub",    32'(bus.out_sub), 32'd0);
    check("rst_bor",    32'(bus.out_borrow), 32'd0);
    check("rst_ovf",    32'(bus.out_overflow), 32'd0);
    check("rst_zero",   32'(bus.out_zero), 32'd0);

    // Start asserted together with reset must be ignored
    bus.in_a = 16'h1111; bus.in_b = 16'h2222; bus.in_start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_start = 1'b0;
    check("rst_start_ignored", 32'(bus.out_busy), 32'd0);
    @(negedge clk);
    check("rst_start_no_run", 32'(bus.out_busy), 32'd0);

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 6; i++) begin
      va = model(1'($urandom_range(1)), 16'($urandom), 16'($urandom), 1'($urandom_range(1)));
      run_op($sformatf("rnd%0d", i), va);
    end

    // Start while busy is ignored; the first result stands
    va = vecs[0];
    vb = mk(1'b1, 16'hAAAA, 16'h1111, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive_start(va, 1'b1);
    bus.in_mode = vb.mode; bus.in_a = vb.a; bus.in_b = vb.b; bus.in_borrow = vb.bin;
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    wait_done("busy_start", N - 1);
    @(negedge clk);
    check("busy_start_no_restart", 32'(bus.out_busy), 32'd0);

    // Back-to-back: start in the DONE cycle
    va = vecs[2];
    vb = model(1'b1, 16'h0F0F, 16'h1234, 1'b0);
    drive_start(va, 1'b1);
    wait_done("b2b_first", N);
    drive_start(vb, 1'b1);
    wait_done("b2b_second", N);
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(bus.out_done), 32'd0);

    // Reset two edges after the start edge aborts the operation
    vc = vecs[1];
    drive_start(vc, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.out_busy), 32'd0);
    check("abort_sub",  32'(bus.out_sub), 32'd0);
    check("abort_done", 32'(bus.out_done), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
